sys_tile_sched: RTL

Tile scheduler for the systolic-array datapath. On a start request it runs a programmed number of tiles. Each tile passes through three phases: weight preload, activation streaming (which stalls on input-buffer backpressure), and pipeline drain. It drives the array's preload, stream and accumulator-clear controls, and reports completion with a one-cycle done pulse. It sits between the top-level layer controller and the array/input-buffer pair.

---
 rtl/sys_tile_sched_if.sv | 45 ++++
 rtl/sys_tile_sched.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sys_tile_sched_if.sv
// ---------------------------------------------------------------------------
// sys_tile_sched_if
// Bundles the tile scheduler's control and status signals.
//   master : layer controller / input buffer side. Drives start, num_tiles,
//            k_len and x_ready. Observes everything else.
//   slave  : the scheduler. Drives busy, done, w_load, w_row, acc_clr,
//            x_valid, out_valid, tile_idx and dbg_state.
// Handshake: a vector moves from the input buffer into the array in a cycle
// where both x_ready (a vector is available) and x_valid (the array takes it)
// are high. x_valid never rises unless x_ready is high.
// start is a level request, looked at only while the scheduler is idle.
// ---------------------------------------------------------------------------
interface sys_tile_sched_if #(
   parameter int ARRAY_N = 8,
   parameter int TILE_W  = 8,
   parameter int K_W     = 10
);
   localparam int ROW_W = $clog2(ARRAY_N);

   logic              start;
   logic [TILE_W-1:0] num_tiles;
   logic [K_W-1:0]    k_len;
   logic              x_ready;
   logic              busy;
   logic              done;
   logic              w_load;
   logic [ROW_W-1:0]  w_row;
   logic              acc_clr;
   logic              x_valid;
   logic              out_valid;
   logic [TILE_W-1:0] tile_idx;
   logic [2:0]        dbg_state;

   modport master (
      output start, num_tiles, k_len, x_ready,
      input  busy, done, w_load, w_row, acc_clr, x_valid, out_valid,
             tile_idx, dbg_state
   );

   modport slave (
      input  start, num_tiles, k_len, x_ready,
      output busy, done, w_load, w_row, acc_clr, x_valid, out_valid,
             tile_idx, dbg_state
   );
endinterface

// File: rtl/sys_tile_sched.sv
// ---------------------------------------------------------------------------
// sys_tile_sched
// Runs a job of num_tiles tiles on the systolic array. Each tile is:
//   WLOAD  : ARRAY_N cycles of weight preload (acc_clr on the first one)
//   STREAM : k_len accepted activation vectors, stalling while x_ready=0
//   DRAIN  : 2*ARRAY_N-1 cycles, results valid on the last ARRAY_N of them
// then a single DONE cycle pulses done.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sys_tile_sched_if.slave (job request, array controls, status)
// Outputs are a pure decode of the state/counter flops, except x_valid which
// follows x_ready during STREAM.
// ---------------------------------------------------------------------------
module sys_tile_sched #(
   parameter int ARRAY_N = 8,
   parameter int TILE_W  = 8,
   parameter int K_W     = 10
) (
   input  logic              clk,
   input  logic              rst,
   sys_tile_sched_if.slave   bus
);
   localparam int ROW_W = $clog2(ARRAY_N);
   // Wide enough for both the drain length and the largest k_len.
   localparam int CNT_W = (K_W > $clog2(2 * ARRAY_N)) ? K_W : $clog2(2 * ARRAY_N);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WLOAD  = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TILE_W-1:0] tile_q, tile_d;
   logic [TILE_W-1:0] ntiles_q, ntiles_d;
   logic [K_W-1:0]    klen_q, klen_d;

   logic wload_last, stream_last, drain_last, tile_last;

   assign wload_last  = (cnt_q == CNT_W'(ARRAY_N - 1));
   // Only evaluated in STREAM, which is never entered with klen_q == 0.
   assign stream_last = (cnt_q == (CNT_W'(klen_q) - CNT_W'(1)));
   assign drain_last  = (cnt_q == CNT_W'(2 * ARRAY_N - 2));
   assign tile_last   = (tile_q == (ntiles_q - TILE_W'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         tile_q   <= '0;
         ntiles_q <= '0;
         klen_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tile_q   <= tile_d;
         ntiles_q <= ntiles_d;
         klen_q   <= klen_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tile_d   = tile_q;
      ntiles_d = ntiles_q;
      klen_d   = klen_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               ntiles_d = bus.num_tiles;
               klen_d   = bus.k_len;
               tile_d   = '0;
               cnt_d    = '0;
               // An empty job still reports completion, without touching the array.
               state_d  = (bus.num_tiles != '0) ? S_WLOAD : S_DONE;
            end
         end
         S_WLOAD: begin
            if (wload_last) begin
               cnt_d   = '0;
               state_d = (klen_q != '0) ? S_STREAM : S_DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STREAM: begin
            // Count only accepted vectors; stalls hold the counter.
            if (bus.x_ready) begin
               if (stream_last) begin
                  cnt_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (drain_last) begin
               cnt_d = '0;
               if (tile_last) begin
                  state_d = S_DONE;
               end else begin
                  tile_d  = tile_q + TILE_W'(1);
                  state_d = S_WLOAD;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.w_load    = (state_q == S_WLOAD);
   assign bus.w_row     = (state_q == S_WLOAD) ? cnt_q[ROW_W-1:0] : '0;
   assign bus.acc_clr   = (state_q == S_WLOAD) && (cnt_q == '0);
   assign bus.x_valid   = (state_q == S_STREAM) && bus.x_ready;
   // The first ARRAY_N-1 drain cycles are pipeline fill; results follow.
   assign bus.out_valid = (state_q == S_DRAIN) && (cnt_q >= CNT_W'(ARRAY_N - 1));
   assign bus.tile_idx  = tile_q;
   assign bus.dbg_state = state_q;

endmodule
